cam_capture_ctrl: RTL and testbench
===================================

Name: cam_capture_ctrl

Overview:
- Frame-level sequencer and RAM write-port arbiter between the camera pixel-capture stage and the dual-port frame buffer.
- Arms single-shot or continuous capture aligned to CAM_vsync, runs a buffer-clear engine, and gates capture writes.
- Counts pixels and lines per frame and reports done, error and frame-count status to the top level.

Parameters:
AW, 15, frame-buffer address width
DW, 12, pixel data width (RGB444)
IMG_SIZE, 19200, pixels per frame (160x120)
IMG_LINES, 120, lines per frame
CLR_VALUE, 12'h000, word written by the clear engine
TIMEOUT_CYC, 2000000, watchdog limit in CAM_pclk cycles (optional feature only)

Ports:
CAM_pclk  in  1  clock
rst  in  1  reset
CAM_vsync  in  1  camera vsync
CAM_href  in  1  camera href
start  in  1  arm a capture (sampled in IDLE)
continuous  in  1  1 = re-arm after each frame
stop  in  1  end continuous mode at the next frame end
clr_req  in  1  fill the buffer with CLR_VALUE (sampled in IDLE)
cap_regW  in  1  write strobe from the capture stage
cap_addr  in  AW  capture write address
cap_data  in  DW  capture write data
DP_RAM_regW  out  1  RAM write enable
DP_RAM_addr_in  out  AW  RAM write address
DP_RAM_data_in  out  DW  RAM write data
busy  out  1  high in any state other than IDLE
frame_done  out  1  one-cycle pulse at frame end
frame_err  out  1  sticky; cleared by start
frame_cnt  out  8  completed frames, wraps 255->0
line_cnt  out  8  lines in the current frame

Behaviour:
- Reset rst: synchronous, active-high. Clock CAM_pclk.
- Reset values: all outputs 0, state IDLE, vsync_q=0, href_q=0, start_pend=0, pix_cnt=0.
- Edge detection:
  - vs_rise = CAM_vsync & ~vsync_q; vs_fall = ~CAM_vsync & vsync_q.
  - href_fall = ~CAM_href & href_q.
  - vsync_q and href_q are registered every cycle.
- RAM port: registered, 1-cycle latency. DP_RAM_regW=0 in every state except CLEAR and CAPTURE.
- State IDLE:
  - clr_req -> CLEAR, clr_addr=0.
  - start alone -> WAIT_VS, clearing frame_err.
  - start and clr_req in the same cycle: clear has priority, start_pend=1, frame_err cleared.
- State CLEAR:
  - Drives regW=1, addr=clr_addr, data=CLR_VALUE; clr_addr+1 each cycle.
  - Write at IMG_SIZE-1 is last. Then goes to WAIT_VS if start_pend (and clears start_pend), else IDLE.
  - Capture strobes are ignored during CLEAR.
- State WAIT_VS: vs_rise -> WAIT_ACT.
- State WAIT_ACT: vs_fall -> CAPTURE, with pix_cnt=0 and line_cnt=0.
- State CAPTURE:
  - Outputs follow cap_regW/cap_addr/cap_data one cycle later.
  - Each accepted cap_regW increments pix_cnt; each href_fall increments line_cnt, saturating at 255.
  - Overflow: a cap_regW when pix_cnt==IMG_SIZE is suppressed (regW=0) and sets frame_err.
- Frame end (vs_rise in CAPTURE):
  - frame_done=1 for one cycle; frame_cnt+1.
  - frame_err set if pix_cnt!=IMG_SIZE or line_cnt!=IMG_LINES.
  - Next state: WAIT_ACT if continuous=1 and stop not seen since arming, else IDLE.
- stop: latched while busy; cleared on entry to IDLE. It does not abort a frame in progress.
- A cap_regW in the same cycle as vs_rise is still written and counted before the end-of-frame check.
- start, clr_req and stop are ignored outside the states listed above.
- rst mid-frame: immediate return to IDLE; any in-flight write is dropped (regW=0 next cycle).

Optional Feature:
- Macro CAM_CAPTURE_TIMEOUT_EN.
- Defined:
  - A 22-bit watchdog counts cycles in WAIT_VS, WAIT_ACT and CAPTURE; it resets on any vsync edge.
  - On reaching TIMEOUT_CYC: go to IDLE, set frame_err and a sticky timeout output (1 bit, cleared by start). No frame_done is issued.
- Not defined: no watchdog logic and no timeout port; the controller waits indefinitely.

Test Plan:
All scenarios use IMG_SIZE=16, IMG_LINES=2, 8 pixels per line.
1. clr_req=1 for one cycle from IDLE -> 16 consecutive writes, addresses 0..15 with data 12'h000, then busy=0; total busy cycles 16.
2. start (single-shot), one valid frame of 2 lines x 8 strobes, cap_data=12'hA5x -> 16 writes passed with 1-cycle latency, one frame_done pulse, frame_err=0, frame_cnt=1, back to IDLE.
3. start and clr_req in the same cycle -> 16 clear writes first, then WAIT_VS; the following frame is captured; frame_cnt=1.
4. continuous=1, 3 frames, stop asserted during frame 2 -> frame_done pulses 2 times, frame_cnt=2, IDLE after frame 2, frame 3 writes absent.
5. Frame with 17 strobes -> 17th write suppressed, frame_err=1 at frame end. Frame with 1 line -> frame_err=1. A following start -> frame_err=0.
6. With CAM_CAPTURE_TIMEOUT_EN and TIMEOUT_CYC=100, start with vsync held low -> timeout=1 and IDLE after 100 cycles. rst asserted mid-CAPTURE -> all outputs 0 next cycle.

Source files
------------

// File: rtl/cam_capture_ctrl.sv
// Camera frame sequencer and frame-buffer write-port arbiter (clear engine + capture gating).
// Optional watchdog enabled with `define CAM_CAPTURE_TIMEOUT_EN (adds the timeout port).
module cam_capture_ctrl #(
  parameter int              AW        = 15,
  parameter int              DW        = 12,
  parameter int              IMG_SIZE  = 19200,
  parameter int              IMG_LINES = 120,
  parameter logic [DW-1:0]   CLR_VALUE = '0
`ifdef CAM_CAPTURE_TIMEOUT_EN
  , parameter int            TIMEOUT_CYC = 2000000
`endif
) (
  input  logic          CAM_pclk,
  input  logic          rst,
  input  logic          CAM_vsync,
  input  logic          CAM_href,
  input  logic          start,
  input  logic          continuous,
  input  logic          stop,
  input  logic          clr_req,
  input  logic          cap_regW,
  input  logic [AW-1:0] cap_addr,
  input  logic [DW-1:0] cap_data,
  output logic          DP_RAM_regW,
  output logic [AW-1:0] DP_RAM_addr_in,
  output logic [DW-1:0] DP_RAM_data_in,
  output logic          busy,
  output logic          frame_done,
  output logic          frame_err,
  output logic [7:0]    frame_cnt,
  output logic [7:0]    line_cnt
`ifdef CAM_CAPTURE_TIMEOUT_EN
  , output logic        timeout
`endif
);

  localparam int PW = $clog2(IMG_SIZE + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, WAIT_VS, WAIT_ACT, CAPTURE} state_t;

  state_t          state_q, state_d;
  logic            vsync_q, href_q;
  logic            start_pend_q, start_pend_d;
  logic            stop_seen_q, stop_seen_d;
  logic [AW-1:0]   clr_addr_q, clr_addr_d;
  logic [PW-1:0]   pix_cnt_q, pix_cnt_d;
  logic [7:0]      line_cnt_q, line_cnt_d;
  logic [7:0]      frame_cnt_q, frame_cnt_d;
  logic            frame_done_q, frame_done_d;
  logic            frame_err_q, frame_err_d;
  logic            busy_q, busy_d;
  logic            ram_we_q, ram_we_d;
  logic [AW-1:0]   ram_addr_q, ram_addr_d;
  logic [DW-1:0]   ram_data_q, ram_data_d;
  logic            arm;
  logic            vs_rise, vs_fall, href_fall;
`ifdef CAM_CAPTURE_TIMEOUT_EN
  logic [21:0]     wd_q, wd_d;
  logic            timeout_q, timeout_d;
`endif

  assign vs_rise   = CAM_vsync & ~vsync_q;
  assign vs_fall   = ~CAM_vsync & vsync_q;
  assign href_fall = ~CAM_href & href_q;

  always_comb begin
    state_d      = state_q;
    start_pend_d = start_pend_q;
    stop_seen_d  = stop_seen_q;
    clr_addr_d   = clr_addr_q;
    pix_cnt_d    = pix_cnt_q;
    line_cnt_d   = line_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    frame_err_d  = frame_err_q;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;
    arm          = 1'b0;
`ifdef CAM_CAPTURE_TIMEOUT_EN
    wd_d         = '0;
    timeout_d    = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
          if (start) begin
            start_pend_d = 1'b1;
            arm          = 1'b1;
          end
        end else if (start) begin
          state_d = WAIT_VS;
          arm     = 1'b1;
        end
      end
      CLEAR: begin
        ram_we_d   = 1'b1;
        ram_addr_d = clr_addr_q;
        ram_data_d = CLR_VALUE;
        clr_addr_d = clr_addr_q + AW'(1);
        if (clr_addr_q == AW'(IMG_SIZE - 1)) begin
          state_d      = start_pend_q ? WAIT_VS : IDLE;
          start_pend_d = 1'b0;
        end
      end
      WAIT_VS: if (vs_rise) state_d = WAIT_ACT;
      WAIT_ACT: begin
        if (vs_fall) begin
          state_d    = CAPTURE;
          pix_cnt_d  = '0;
          line_cnt_d = '0;
        end
      end
      CAPTURE: begin
        ram_addr_d = cap_addr;
        ram_data_d = cap_data;
        if (cap_regW) begin
          if (pix_cnt_q == PW'(IMG_SIZE)) begin
            frame_err_d = 1'b1;
          end else begin
            ram_we_d  = 1'b1;
            pix_cnt_d = pix_cnt_q + PW'(1);
          end
        end
        if (href_fall && line_cnt_q != 8'd255) line_cnt_d = line_cnt_q + 8'd1;
        // Frame end uses the counts updated by this same cycle's strobe/href edge.
        if (vs_rise) begin
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 8'd1;
          if (pix_cnt_d != PW'(IMG_SIZE) || line_cnt_d != 8'(IMG_LINES)) frame_err_d = 1'b1;
          state_d = (continuous && !(stop_seen_q || stop)) ? WAIT_ACT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (arm) frame_err_d = 1'b0;
`ifdef CAM_CAPTURE_TIMEOUT_EN
    if (arm) timeout_d = 1'b0;
    if (state_q == WAIT_VS || state_q == WAIT_ACT || state_q == CAPTURE) begin
      if (!(vs_rise || vs_fall)) begin
        wd_d = wd_q + 22'd1;
        if (wd_d == 22'(TIMEOUT_CYC)) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
          timeout_d   = 1'b1;
          wd_d        = '0;
        end
      end
    end
`endif
    if (state_q != IDLE && stop) stop_seen_d = 1'b1;
    if (state_d == IDLE) stop_seen_d = 1'b0;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CAM_pclk) begin
    if (rst) begin
      state_q      <= IDLE;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      start_pend_q <= 1'b0;
      stop_seen_q  <= 1'b0;
      clr_addr_q   <= '0;
      pix_cnt_q    <= '0;
      line_cnt_q   <= '0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
`ifdef CAM_CAPTURE_TIMEOUT_EN
      wd_q         <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      vsync_q      <= CAM_vsync;
      href_q       <= CAM_href;
      start_pend_q <= start_pend_d;
      stop_seen_q  <= stop_seen_d;
      clr_addr_q   <= clr_addr_d;
      pix_cnt_q    <= pix_cnt_d;
      line_cnt_q   <= line_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
`ifdef CAM_CAPTURE_TIMEOUT_EN
      wd_q         <= wd_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign DP_RAM_regW    = ram_we_q;
  assign DP_RAM_addr_in = ram_addr_q;
  assign DP_RAM_data_in = ram_data_q;
  assign busy           = busy_q;
  assign frame_done     = frame_done_q;
  assign frame_err      = frame_err_q;
  assign frame_cnt      = frame_cnt_q;
  assign line_cnt       = line_cnt_q;
`ifdef CAM_CAPTURE_TIMEOUT_EN
  assign timeout        = timeout_q;
`endif

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Scoreboard bench for cam_capture_ctrl: small frames (16 px, 2 lines of 8).
module tb_cam_capture_ctrl;
  localparam int AW = 15;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst, CAM_vsync, CAM_href, start, continuous, stop, clr_req, cap_regW;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_data;
  logic          DP_RAM_regW, busy, frame_done, frame_err;
  logic [AW-1:0] DP_RAM_addr_in;
  logic [DW-1:0] DP_RAM_data_in;
  logic [7:0]    frame_cnt, line_cnt;
`ifdef CAM_CAPTURE_TIMEOUT_EN
  logic          timeout;
`endif

  int assertions = 0;
  int failures   = 0;
  int done_cnt   = 0;
  int pix_idx    = 0;
  logic [AW+DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  cam_capture_ctrl #(
    .AW(AW), .DW(DW), .IMG_SIZE(16), .IMG_LINES(2), .CLR_VALUE(12'h000)
`ifdef CAM_CAPTURE_TIMEOUT_EN
    , .TIMEOUT_CYC(100)
`endif
  ) dut (
    .CAM_pclk(clk), .rst(rst), .CAM_vsync(CAM_vsync), .CAM_href(CAM_href),
    .start(start), .continuous(continuous), .stop(stop), .clr_req(clr_req),
    .cap_regW(cap_regW), .cap_addr(cap_addr), .cap_data(cap_data),
    .DP_RAM_regW(DP_RAM_regW), .DP_RAM_addr_in(DP_RAM_addr_in), .DP_RAM_data_in(DP_RAM_data_in),
    .busy(busy), .frame_done(frame_done), .frame_err(frame_err),
    .frame_cnt(frame_cnt), .line_cnt(line_cnt)
`ifdef CAM_CAPTURE_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );

  // Write-port monitor: every RAM write must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst === 1'b0 && DP_RAM_regW === 1'b1) begin
      assertions++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", DP_RAM_addr_in, DP_RAM_data_in);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        if ({DP_RAM_addr_in, DP_RAM_data_in} !== e) begin
          failures++;
          $display("FAIL write_data: got addr=%0d data=%h, expected addr=%0d data=%h",
                   DP_RAM_addr_in, DP_RAM_data_in, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
    if (rst === 1'b0 && frame_done === 1'b1) done_cnt++;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; CAM_vsync = 0; CAM_href = 0; start = 0; continuous = 0; stop = 0;
    clr_req = 0; cap_regW = 0; cap_addr = '0; cap_data = '0;
    tick(3);
    rst = 1'b0;
    exp_q.delete();
    done_cnt = 0;
    tick(1);
  endtask

  task automatic vs_pulse();
    CAM_vsync = 1'b1;
    tick(3);
    CAM_vsync = 1'b0;
    tick(2);
  endtask

  task automatic send_line(input int n, input bit expect_on);
    CAM_href = 1'b1;
    for (int i = 0; i < n; i++) begin
      cap_regW = 1'b1;
      cap_addr = AW'(pix_idx);
      cap_data = 12'hA50 | DW'(pix_idx & 15);
      if (expect_on && pix_idx < 16) exp_q.push_back({cap_addr, cap_data});
      pix_idx++;
      tick(1);
    end
    cap_regW = 1'b0;
    CAM_href = 1'b0;
    tick(2);
  endtask

  task automatic check_queue_empty(input string name);
    assertions++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s: %0d expected writes missing, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    do_reset();
    assertions++;
    if ({DP_RAM_regW, DP_RAM_addr_in, DP_RAM_data_in} !== '0) begin
      failures++; $display("FAIL reset_ram: got %b/%0d/%h, required 0", DP_RAM_regW, DP_RAM_addr_in, DP_RAM_data_in);
    end
    assertions++;
    if ({busy, frame_done, frame_err, frame_cnt, line_cnt} !== '0) begin
      failures++; $display("FAIL reset_status: got busy=%b done=%b err=%b fcnt=%0d lcnt=%0d, required all 0",
                           busy, frame_done, frame_err, frame_cnt, line_cnt);
    end
  endtask

  task automatic test_clear();
    int busy_cycles = 0;
    do_reset();
    for (int i = 0; i < 16; i++) exp_q.push_back({AW'(i), 12'h000});
    clr_req = 1'b1;
    tick(1);
    clr_req = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (busy === 1'b1) busy_cycles++;
      tick(1);
    end
    check_queue_empty("clear_writes");
    assertions++;
    if (busy_cycles != 16) begin
      failures++; $display("FAIL clear_busy_cycles: got %0d, required 16", busy_cycles);
    end
  endtask

  task automatic test_single_frame();
    do_reset();
    pix_idx = 0;
    start = 1'b1; tick(1); start = 1'b0;
    vs_pulse();
    send_line(8, 1'b1);
    send_line(8, 1'b1);
    vs_pulse();
    tick(2);
    check_queue_empty("single_writes");
    assertions++;
    if (done_cnt != 1) begin failures++; $display("FAIL single_done: got %0d pulses, required 1", done_cnt); end
    assertions++;
    if ({frame_err, frame_cnt, line_cnt, busy} !== {1'b0, 8'd1, 8'd2, 1'b0}) begin
      failures++; $display("FAIL single_status: got err=%b fcnt=%0d lcnt=%0d busy=%b, required 0/1/2/0",
                           frame_err, frame_cnt, line_cnt, busy);
    end
  endtask

  task automatic test_clear_then_start();
    do_reset();
    for (int i = 0; i < 16; i++) exp_q.push_back({AW'(i), 12'h000});
    start = 1'b1; clr_req = 1'b1; tick(1); start = 1'b0; clr_req = 1'b0;
    tick(20);
    check_queue_empty("pend_clear_writes");
    assertions++;
    if (busy !== 1'b1) begin failures++; $display("FAIL pend_wait_vs: got busy=%b, required 1", busy); end
    pix_idx = 0;
    vs_pulse();
    send_line(8, 1'b1);
    send_line(8, 1'b1);
    vs_pulse();
    tick(2);
    check_queue_empty("pend_capture_writes");
    assertions++;
    if ({frame_cnt, frame_err, busy} !== {8'd1, 1'b0, 1'b0}) begin
      failures++; $display("FAIL pend_status: got fcnt=%0d err=%b busy=%b, required 1/0/0", frame_cnt, frame_err, busy);
    end
  endtask

  task automatic test_continuous_stop();
    do_reset();
    continuous = 1'b1;
    start = 1'b1; tick(1); start = 1'b0;
    vs_pulse();
    pix_idx = 0; send_line(8, 1'b1); send_line(8, 1'b1);
    vs_pulse();
    pix_idx = 0;
    stop = 1'b1; tick(1); stop = 1'b0;
    send_line(8, 1'b1); send_line(8, 1'b1);
    vs_pulse();
    assertions++;
    if (busy !== 1'b0) begin failures++; $display("FAIL cont_idle_after_f2: got busy=%b, required 0", busy); end
    pix_idx = 0; send_line(8, 1'b0); send_line(8, 1'b0);
    vs_pulse();
    tick(2);
    check_queue_empty("cont_writes");
    assertions++;
    if (done_cnt != 2) begin failures++; $display("FAIL cont_done: got %0d pulses, required 2", done_cnt); end
    assertions++;
    if ({frame_cnt, frame_err} !== {8'd2, 1'b0}) begin
      failures++; $display("FAIL cont_status: got fcnt=%0d err=%b, required 2/0", frame_cnt, frame_err);
    end
    continuous = 1'b0;
  endtask

  task automatic test_errors();
    do_reset();
    start = 1'b1; tick(1); start = 1'b0;
    vs_pulse();
    pix_idx = 0; send_line(8, 1'b1); send_line(9, 1'b1);
    vs_pulse();
    tick(2);
    check_queue_empty("ovf_writes");
    assertions++;
    if (frame_err !== 1'b1) begin failures++; $display("FAIL ovf_err: got %b, required 1", frame_err); end
    start = 1'b1; tick(1); start = 1'b0;
    assertions++;
    if (frame_err !== 1'b0) begin failures++; $display("FAIL start_clears_err: got %b, required 0", frame_err); end
    vs_pulse();
    pix_idx = 0; send_line(16, 1'b1);
    vs_pulse();
    tick(2);
    check_queue_empty("oneline_writes");
    assertions++;
    if ({frame_err, line_cnt} !== {1'b1, 8'd1}) begin
      failures++; $display("FAIL oneline_err: got err=%b lcnt=%0d, required 1/1", frame_err, line_cnt);
    end
    start = 1'b1; tick(1); start = 1'b0;
    assertions++;
    if (frame_err !== 1'b0) begin failures++; $display("FAIL restart_clears_err: got %b, required 0", frame_err); end
  endtask

  task automatic test_reset_mid_capture();
    do_reset();
    start = 1'b1; tick(1); start = 1'b0;
    vs_pulse();
    pix_idx = 0;
    send_line(8, 1'b1);
    CAM_href = 1'b1;
    cap_regW = 1'b1; cap_addr = AW'(8); cap_data = 12'hA58;
    rst = 1'b1;
    tick(1);
    assertions++;
    if ({DP_RAM_regW, busy, frame_cnt, line_cnt, frame_err} !== '0) begin
      failures++; $display("FAIL rst_mid_capture: got we=%b busy=%b fcnt=%0d lcnt=%0d err=%b, required all 0",
                           DP_RAM_regW, busy, frame_cnt, line_cnt, frame_err);
    end
    rst = 1'b0;
    tick(3);
    cap_regW = 1'b0; CAM_href = 1'b0;
    tick(1);
    check_queue_empty("rst_mid_writes");
  endtask

`ifdef CAM_CAPTURE_TIMEOUT_EN
  task automatic test_timeout();
    int busy_cycles = 0;
    do_reset();
    start = 1'b1; tick(1); start = 1'b0;
    for (int i = 0; i < 130; i++) begin
      if (busy === 1'b1) busy_cycles++;
      tick(1);
    end
    assertions++;
    if (busy_cycles < 99 || busy_cycles > 101) begin
      failures++; $display("FAIL timeout_cycles: got %0d busy cycles, required about 100", busy_cycles);
    end
    assertions++;
    if ({timeout, frame_err, busy} !== 3'b110 || done_cnt != 0) begin
      failures++; $display("FAIL timeout_status: got to=%b err=%b busy=%b done=%0d, required 1/1/0/0",
                           timeout, frame_err, busy, done_cnt);
    end
    start = 1'b1; tick(1); start = 1'b0;
    assertions++;
    if ({timeout, frame_err} !== 2'b00) begin
      failures++; $display("FAIL timeout_clear: got to=%b err=%b, required 0/0", timeout, frame_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_clear();
    test_single_frame();
    test_clear_then_start();
    test_continuous_stop();
    test_errors();
    test_reset_mid_capture();
`ifdef CAM_CAPTURE_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule
